// File: rtl/voice_allocator_pkg.sv
// Shared types and widths for the polyphonic voice allocator.
package synth_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, GAP} alloc_state_t;

    localparam int NOTE_W         = 8;
    localparam int AMP_W          = 16;
    localparam int DEF_NUM_VOICES = 4;
endpackage

// File: rtl/voice_allocator_if.sv
// Note-event valid/ready handshake from the NIOS II side into the allocator.
interface voice_allocator_if;
    import synth_pkg::*;

    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [AMP_W-1:0]  ev_amp;

    modport master (output ev_valid, ev_on, ev_note, ev_amp, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_note, ev_amp, output ev_ready);
endinterface

// File: rtl/voice_allocator_slot.sv
// One voice slot: frequency code, amplitude, gate and saturating age.
module voice_slot import synth_pkg::*; #(
    parameter int AGE_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load,
    input  logic              set_amp,
    input  logic              gate_off,
    input  logic              all_clear,
    input  logic              age_inc,
    input  logic              age_clr,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [AMP_W-1:0]  amp_in,
    output logic [NOTE_W-1:0] note,
    output logic [AMP_W-1:0]  amp,
    output logic              gate,
    output logic [AGE_W-1:0]  age
);
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            note <= '0;
            amp  <= '0;
            gate <= 1'b0;
            age  <= '0;
        end else begin
            if (load) begin
                note <= note_in;
                amp  <= amp_in;
            end else if (set_amp) begin
                amp <= amp_in;
            end

            // note and amp survive gate-off so the release tail keeps its pitch
            if (all_clear || gate_off)
                gate <= 1'b0;
            else if (load)
                gate <= 1'b1;

            if (all_clear || age_clr)
                age <= '0;
            else if (age_inc && (age != '1))
                age <= age + 1'b1;
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Assigns note events to voice slots: match, then free, then steal the oldest.
// state  | meaning
// IDLE   | waiting for an event; all_off panic handled here
// SCAN   | one voice per cycle: match / free / oldest search
// COMMIT | apply the chosen action to the target voice
// GAP    | key_on held low on a stolen voice before retrigger
module voice_allocator import synth_pkg::*; #(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int AGE_W      = 8,
    parameter int GAP_CYCLES = 2048
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    voice_allocator_if.slave             ev,
    input  logic                         all_off,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [AMP_W*NUM_VOICES-1:0]  voice_amp,
    output logic [NUM_VOICES-1:0]        key_on,
    output logic                         stolen,
    output logic                         dropped
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [NUM_VOICES-1:0] ONE = NUM_VOICES'(1);

    alloc_state_t state, nxt;

    logic [IDX_W-1:0]  idx, match_idx, free_idx, old_idx, tgt;
    logic              found_match, found_free, found_old;
    logic [AGE_W-1:0]  old_age;
    logic              lat_on;
    logic [NOTE_W-1:0] lat_note;
    logic [AMP_W-1:0]  lat_amp;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept, all_clr;

    logic [NUM_VOICES-1:0] load_v, amp_v, off_v, inc_v, clr_v;
    logic [NOTE_W-1:0]     s_note [NUM_VOICES];
    logic [AMP_W-1:0]      s_amp  [NUM_VOICES];
    logic [AGE_W-1:0]      s_age  [NUM_VOICES];

    assign ev.ev_ready = (state == IDLE) && !all_off;
    assign accept      = ev.ev_ready && ev.ev_valid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt     = state;
        stolen  = 1'b0;
        dropped = 1'b0;
        all_clr = 1'b0;
        load_v  = '0;
        amp_v   = '0;
        off_v   = '0;
        inc_v   = '0;
        clr_v   = '0;
        tgt     = found_match ? match_idx : (found_free ? free_idx : old_idx);
        case (state)
            IDLE: begin
                if (all_off)     all_clr = 1'b1;
                else if (accept) nxt = SCAN;
            end
            SCAN: begin
                if (idx == IDX_W'(NUM_VOICES - 1)) nxt = COMMIT;
            end
            COMMIT: begin
                nxt = IDLE;
                if (lat_on) begin
                    inc_v = key_on & ~(ONE << tgt);
                    clr_v = ONE << tgt;
                    if (found_match) begin
                        amp_v = ONE << tgt;
                    end else if (found_free) begin
                        load_v = ONE << tgt;
                    end else begin
                        off_v  = ONE << tgt;
                        stolen = 1'b1;
                        nxt    = GAP;
                    end
                end else if (found_match) begin
                    off_v = ONE << match_idx;
                    clr_v = ONE << match_idx;
                end else begin
                    dropped = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    load_v = ONE << old_idx;
                    nxt    = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx         <= '0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_amp     <= '0;
            found_match <= 1'b0;
            found_free  <= 1'b0;
            found_old   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    lat_on      <= ev.ev_on;
                    lat_note    <= ev.ev_note;
                    lat_amp     <= ev.ev_amp;
                    idx         <= '0;
                    found_match <= 1'b0;
                    found_free  <= 1'b0;
                    found_old   <= 1'b0;
                    old_age     <= '0;
                end
                SCAN: begin
                    if (key_on[idx] && (s_note[idx] == lat_note) && !found_match) begin
                        found_match <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!key_on[idx] && !found_free) begin
                        found_free <= 1'b1;
                        free_idx   <= idx;
                    end
                    // strict compare keeps the lowest index on an age tie
                    if (key_on[idx] && (!found_old || (s_age[idx] > old_age))) begin
                        found_old <= 1'b1;
                        old_idx   <= idx;
                        old_age   <= s_age[idx];
                    end
                    idx <= idx + 1'b1;
                end
                COMMIT: gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                GAP:    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .load      (load_v[i]),
            .set_amp   (amp_v[i]),
            .gate_off  (off_v[i]),
            .all_clear (all_clr),
            .age_inc   (inc_v[i]),
            .age_clr   (clr_v[i]),
            .note_in   (lat_note),
            .amp_in    (lat_amp),
            .note      (s_note[i]),
            .amp       (s_amp[i]),
            .gate      (key_on[i]),
            .age       (s_age[i])
        );
        assign voice_note[NOTE_W*i +: NOTE_W] = s_note[i];
        assign voice_amp[AMP_W*i +: AMP_W]    = s_amp[i];
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with an event-timeline reference model.
module tb_voice_allocator;
    localparam int NV  = 4;
    localparam int GAP = 16;
    localparam int K_MATCH = 0, K_FREE = 1, K_STEAL = 2, K_OFF = 3, K_DROP = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        all_off = 1'b0;
    logic [31:0] voice_note;
    logic [63:0] voice_amp;
    logic [3:0]  key_on;
    logic        stolen, dropped;

    voice_allocator_if ev_if();

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8), .GAP_CYCLES(GAP)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ev         (ev_if),
        .all_off    (all_off),
        .voice_note (voice_note),
        .voice_amp  (voice_amp),
        .key_on     (key_on),
        .stolen     (stolen),
        .dropped    (dropped)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: per-voice state plus one pending event with absolute cycle stamps
    logic [7:0]  m_note [NV];
    logic [15:0] m_amp  [NV];
    bit          m_key  [NV];
    int          m_age  [NV];
    bit          pend;
    int          kind, tgt, t_commit, t_done;
    logic [7:0]  p_note;
    logic [15:0] p_amp;
    logic [31:0] e_note;
    logic [63:0] e_amp;
    logic [3:0]  e_key;
    int          mi, fi, oi;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NV; i++) begin
                m_note[i] = '0; m_amp[i] = '0; m_key[i] = 1'b0; m_age[i] = 0;
            end
            pend = 1'b0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                e_note[8*i +: 8]   = m_note[i];
                e_amp[16*i +: 16]  = m_amp[i];
                e_key[i]           = m_key[i];
            end
            chk("key_on", key_on, e_key);
            chk("voice_note", voice_note, e_note);
            chk("voice_amp", voice_amp, e_amp);
            chk("ev_ready", ev_if.ev_ready, !pend && !all_off);
            chk("stolen", stolen, pend && cyc == t_commit && kind == K_STEAL);
            chk("dropped", dropped, pend && cyc == t_commit && kind == K_DROP);

            if (pend) begin
                if (cyc == t_commit) begin
                    if (kind <= K_STEAL) begin
                        for (int i = 0; i < NV; i++)
                            if (i != tgt && m_key[i] && m_age[i] < 255) m_age[i]++;
                        m_age[tgt] = 0;
                    end
                    case (kind)
                        K_MATCH: m_amp[tgt] = p_amp;
                        K_FREE:  begin m_note[tgt] = p_note; m_amp[tgt] = p_amp; m_key[tgt] = 1'b1; end
                        K_STEAL: m_key[tgt] = 1'b0;
                        K_OFF:   begin m_key[tgt] = 1'b0; m_age[tgt] = 0; end
                        default: ;
                    endcase
                end
                if (cyc + 1 == t_done) begin
                    if (kind == K_STEAL) begin
                        m_note[tgt] = p_note; m_amp[tgt] = p_amp; m_key[tgt] = 1'b1;
                    end
                    pend = 1'b0;
                end
            end else if (all_off) begin
                for (int i = 0; i < NV; i++) begin m_key[i] = 1'b0; m_age[i] = 0; end
            end else if (ev_if.ev_valid) begin
                mi = -1; fi = -1; oi = -1;
                for (int i = 0; i < NV; i++) begin
                    if (m_key[i] && m_note[i] == ev_if.ev_note && mi < 0) mi = i;
                    if (!m_key[i] && fi < 0) fi = i;
                    if (m_key[i] && (oi < 0 || m_age[i] > m_age[oi])) oi = i;
                end
                if (ev_if.ev_on) begin
                    if (mi >= 0)      begin kind = K_MATCH; tgt = mi; end
                    else if (fi >= 0) begin kind = K_FREE;  tgt = fi; end
                    else              begin kind = K_STEAL; tgt = oi; end
                end else begin
                    kind = (mi >= 0) ? K_OFF : K_DROP;
                    tgt  = (mi >= 0) ? mi : 0;
                end
                p_note   = ev_if.ev_note;
                p_amp    = ev_if.ev_amp;
                pend     = 1'b1;
                t_commit = cyc + NV + 1;
                t_done   = cyc + NV + 2 + ((kind == K_STEAL) ? GAP : 0);
            end
        end
    end

    task automatic send(input logic on, input logic [7:0] n, input logic [15:0] a, output int hs);
        int guard;
        guard = 0;
        hs = -1000;
        @(posedge Clk); #1;
        ev_if.ev_valid = 1'b1; ev_if.ev_on = on; ev_if.ev_note = n; ev_if.ev_amp = a;
        forever begin
            @(negedge Clk);
            if (ev_if.ev_ready) begin hs = cyc; break; end
            guard++;
            if (guard > 200) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: ev_ready stayed %0b, required 1", ev_if.ev_ready);
                break;
            end
        end
        @(posedge Clk); #1;
        ev_if.ev_valid = 1'b0;
    endtask

    task automatic wait_to(input int c);
        int guard;
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
        end while (cyc < c && guard < 500);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
        end while (!ev_if.ev_ready && guard < 200);
        if (!ev_if.ev_ready) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: ev_ready %0b, required 1", ev_if.ev_ready);
        end
    endtask

    int hs;

    initial begin
        ev_if.ev_valid = 1'b0; ev_if.ev_on = 1'b0; ev_if.ev_note = '0; ev_if.ev_amp = '0;
        #12 Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_ready", ev_if.ev_ready, 1'b1);
        chk("rst_key_on", key_on, 4'h0);
        chk("rst_note", voice_note, 32'h0);

        // first note lands on voice 0 after N+2 cycles
        send(1'b1, 8'h40, 16'h1000, hs);
        wait_to(hs + 1); chk("busy_ready_first", ev_if.ev_ready, 1'b0);
        wait_to(hs + 5); chk("busy_ready_last", ev_if.ev_ready, 1'b0);
                         chk("pre_commit_key", key_on, 4'h0);
        wait_to(hs + 6); chk("v0_note", voice_note[7:0], 8'h40);
                         chk("v0_amp", voice_amp[15:0], 16'h1000);
                         chk("v0_key", key_on, 4'b0001);
                         chk("ready_back", ev_if.ev_ready, 1'b1);

        send(1'b1, 8'h43, 16'h1100, hs); wait_idle();
        send(1'b1, 8'h47, 16'h1200, hs); wait_idle();
        send(1'b1, 8'h4A, 16'h1300, hs); wait_idle();
        chk("fill_key", key_on, 4'hF);
        chk("fill_notes", voice_note, 32'h4A474340);

        // fifth note steals voice 0 (oldest)
        send(1'b1, 8'h4C, 16'h1400, hs);
        wait_to(hs + 5);  chk("steal_pulse", stolen, 1'b1);
        wait_to(hs + 6);  chk("gap_start_key", key_on, 4'b1110);
        wait_to(hs + 21); chk("gap_end_key", key_on, 4'b1110);
                          chk("gap_ready", ev_if.ev_ready, 1'b0);
        wait_to(hs + 22); chk("steal_key", key_on, 4'hF);
                          chk("steal_notes", voice_note, 32'h4A47434C);
                          chk("steal_amp", voice_amp[15:0], 16'h1400);

        // repeated note updates amplitude only
        send(1'b1, 8'h43, 16'h2000, hs);
        wait_to(hs + 6);  chk("match_amp", voice_amp[31:16], 16'h2000);
                          chk("match_key", key_on, 4'hF);

        send(1'b0, 8'h47, 16'h0000, hs);
        wait_to(hs + 6);  chk("off_key", key_on, 4'b1011);
                          chk("off_note_kept", voice_note[23:16], 8'h47);

        send(1'b0, 8'h50, 16'h0000, hs);
        wait_to(hs + 5);  chk("drop_pulse", dropped, 1'b1);
        wait_to(hs + 6);  chk("drop_key", key_on, 4'b1011);

        // panic with an event presented at the same time
        @(posedge Clk); #1;
        all_off = 1'b1; ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 8'h55;
        @(negedge Clk);   chk("alloff_ready", ev_if.ev_ready, 1'b0);
        @(posedge Clk); #1;
        all_off = 1'b0; ev_if.ev_valid = 1'b0;
        @(negedge Clk);   chk("alloff_key", key_on, 4'h0);
                          chk("alloff_notes", voice_note, 32'h4A47434C);

        send(1'b1, 8'h30, 16'h0A00, hs); wait_idle();
        send(1'b1, 8'h31, 16'h0A01, hs); wait_idle();
        send(1'b1, 8'h32, 16'h0A02, hs); wait_idle();
        send(1'b1, 8'h33, 16'h0A03, hs); wait_idle();
        chk("refill_notes", voice_note, 32'h33323130);
        send(1'b1, 8'h34, 16'h0A04, hs);
        wait_to(hs + 10); chk("gap2_key", key_on, 4'b1110);

        // reset in the middle of GAP
        @(posedge Clk); #3;
        Reset_n = 1'b0;
        #1;
        chk("rst_gap_key", key_on, 4'h0);
        chk("rst_gap_note", voice_note, 32'h0);
        chk("rst_gap_amp", voice_amp, 64'h0);
        @(negedge Clk); #2;
        Reset_n = 1'b1;
        @(negedge Clk);   chk("post_rst_ready", ev_if.ev_ready, 1'b1);
        repeat (3) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
